alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer for the shared ALU. It accepts operation requests from two requesters over valid/ready handshakes. Port 0 is the core pipeline and port 1 is the bucket-sort engine. It grants them round-robin, drives the ALU from latched operands, and holds the multiply ops for a programmable number of cycles. It owns the 64-bit HI/LO accumulator for mul/madd/maddu and returns each result with the requester ID.

## Interface
- MULT_CYCLES, 2, EXEC cycles spent on ctrl 00100/00101/00110; legal range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  accept strobe; a transfer occurs when valid & ready
- req0_ctrl / req1_ctrl  in  5  ALU operation code
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_shift / req1_shift  in  5  shift amount
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the op (0/1)
- rsp_result  out  32  captured ALU result
- rsp_is_zero, rsp_is_negative  out  1  captured ALU flags
- hi_lo  out  64  HI/LO accumulator
- alu_a, alu_b  out  32  ALU operands
- alu_ctrl  out  5  ALU operation code
- alu_shift  out  5  ALU shift amount
- alu_mult_in  out  64  equals hi_lo
- alu_result  in  32  ALU result
- alu_mult_res  in  64  ALU 64-bit product
- alu_is_zero, alu_is_negative  in  1  ALU flags

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If any reqN_valid, grant one requester by round-robin.
  - Assert reqN_ready combinationally for the granted port only.
  - Latch ctrl/a/b/shift and the ID, load cnt, then go to EXEC.
  - reqN_ready is 0 in every other state.
- Round-robin: a `last` register holds the previous grant.
  - With both ports valid, the port ≠ `last` wins.
  - With one port valid, that port wins.
  - `last` resets to 1, so port 0 wins the first tie.
- EXEC
  - alu_* outputs are driven from the latched registers; they hold their values in all states.
  - A mult op is ctrl ∈ {00100, 00101, 00110}.
  - cnt loads MULT_CYCLES-1 for a mult op, otherwise 0.
  - Each EXEC cycle with cnt≠0 decrements cnt.
  - When cnt==0: capture alu_result/flags into rsp_*, update hi_lo, go to RESP.
- HI/LO update on the capture edge only:
  - 00100: hi_lo ← alu_mult_res
  - 00101 and 00110: hi_lo ← hi_lo + alu_mult_res, 64-bit modulo (carry out discarded)
  - All other codes leave hi_lo unchanged.
- Undefined ctrl codes pass through to the ALU unchecked and are treated as non-mult.
- RESP
  - rsp_valid=1, and rsp_* are held stable until rsp_valid & rsp_ready.
  - Then go to IDLE. No new grant happens in that same cycle.
- Reset (asynchronous, any state)
  - Forces IDLE, last=1, cnt=0.
  - All outputs go to 0: req*_ready, rsp_valid, rsp_id, rsp_result, flags, hi_lo, alu_*.
  - An in-flight op is dropped with no response, and hi_lo is lost.

## Timing
- Handshake at edge T. EXEC occupies cycles T+1 .. T+K, where K=1 for non-mult ops and K=MULT_CYCLES for mult ops.
- rsp_valid rises in cycle T+K+1.
- If rsp_ready is high on arrival, the response handshakes at the end of T+K+1. IDLE is cycle T+K+2, and the next grant can handshake at that edge.
- Minimum issue interval: 3 cycles for non-mult ops, MULT_CYCLES+2 for mult ops.
- A requester may change its payload only after its handshake.
- A requester held off by the other port keeps valid asserted. Round-robin guarantees it is served on the next grant.
- Reset deassertion: the first grant is possible on the first rising edge after rst goes high.

## Test plan
- Single add, port 0 (a=5, b=7, ctrl 00000, rsp_ready=1) -> rsp_valid 2 cycles after accept; rsp_result=12, rsp_id=0, rsp_is_zero=0.
- Both ports valid continuously after reset (port0 sub 3-3, port1 or 0xF0|0x0F) -> grants alternate 0,1,0; port 0 response has rsp_result=0 and is_zero=1; port 1 response has rsp_result=0xFF.
- MULT_CYCLES=3: mul 0x10000×0x10000, then madd 2×3 -> first response 4 cycles after accept with hi_lo=0x1_0000_0000; after the madd, hi_lo=0x1_0000_0006.
- hi_lo=0xFFFF_FFFF_FFFF_FFFF, then maddu 1×1 -> hi_lo wraps to 0.
- rsp_ready held low for 5 cycles -> rsp_* stable, rsp_valid held, both req*_ready=0; no grant until the cycle after rsp_ready rises.
- rst asserted in the middle of EXEC of a mult op -> all outputs 0 immediately, no response; a fresh port-1-only request after release is served normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin two-port front end for the shared ALU: latches one request, runs it
// for 1 or MULT_CYCLES cycles, owns the HI/LO accumulator and returns the result.
module alu_arbiter #(
  parameter int unsigned MULT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_ctrl,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shift,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_ctrl,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shift,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_is_zero,
  output logic        rsp_is_negative,
  output logic [63:0] hi_lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_ctrl,
  output logic [4:0]  alu_shift,
  output logic [63:0] alu_mult_in,
  input  logic [31:0] alu_result,
  input  logic [63:0] alu_mult_res,
  input  logic        alu_is_zero,
  input  logic        alu_is_negative,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a request transfers on the rising edge where reqN_valid & reqN_ready,
  // a response on the edge where rsp_valid & rsp_ready. A held-off requester keeps
  // valid high; a response stays stable until it transfers.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

  state_t      state_q;
  logic        last_q;
  logic        id_q;
  logic [3:0]  cnt_q;

  logic        gnt_id;
  logic        grant;
  logic [4:0]  sel_ctrl;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [4:0]  sel_shift;

  function automatic logic is_mult(input logic [4:0] c);
    return (c == 5'b00100) || (c == 5'b00101) || (c == 5'b00110);
  endfunction

  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    grant      = rst && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = grant && !gnt_id;
    req1_ready = grant && gnt_id;
    sel_ctrl   = gnt_id ? req1_ctrl  : req0_ctrl;
    sel_a      = gnt_id ? req1_a     : req0_a;
    sel_b      = gnt_id ? req1_b     : req0_b;
    sel_shift  = gnt_id ? req1_shift : req0_shift;
  end

  assign alu_mult_in = hi_lo;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      last_q          <= 1'b1;
      id_q            <= 1'b0;
      cnt_q           <= 4'd0;
      rsp_valid       <= 1'b0;
      rsp_id          <= 1'b0;
      rsp_result      <= 32'd0;
      rsp_is_zero     <= 1'b0;
      rsp_is_negative <= 1'b0;
      hi_lo           <= 64'd0;
      alu_a           <= 32'd0;
      alu_b           <= 32'd0;
      alu_ctrl        <= 5'd0;
      alu_shift       <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            alu_ctrl  <= sel_ctrl;
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_shift <= sel_shift;
            id_q      <= gnt_id;
            last_q    <= gnt_id;
            cnt_q     <= is_mult(sel_ctrl) ? MULT_LOAD : 4'd0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rsp_valid       <= 1'b1;
            rsp_id          <= id_q;
            rsp_result      <= alu_result;
            rsp_is_zero     <= alu_is_zero;
            rsp_is_negative <= alu_is_negative;
            // Accumulate wraps modulo 2^64; the carry out is intentionally dropped.
            case (alu_ctrl)
              5'b00100:          hi_lo <= alu_mult_res;
              5'b00101, 5'b00110: hi_lo <= hi_lo + alu_mult_res;
              default:           hi_lo <= hi_lo;
            endcase
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed cases and random two-port traffic,
// with a queue-based scoreboard checking results, latency, grants and HI/LO.
module tb_alu_arbiter;

  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_ctrl, req1_ctrl, req0_shift, req1_shift;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_is_zero, rsp_is_negative;
  logic [31:0] rsp_result;
  logic [63:0] hi_lo, alu_mult_in, alu_mult_res;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_ctrl, alu_shift;
  logic        alu_is_zero, alu_is_negative;
  logic [1:0]  dbg_state;

  alu_arbiter #(.MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_is_zero(rsp_is_zero), .rsp_is_negative(rsp_is_negative),
    .hi_lo(hi_lo), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_shift(alu_shift), .alu_mult_in(alu_mult_in), .alu_result(alu_result),
    .alu_mult_res(alu_mult_res), .alu_is_zero(alu_is_zero),
    .alu_is_negative(alu_is_negative), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU ----------------
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_res(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] p;
    p = ref_prod(a, b);
    case (c)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4, 5'd5, 5'd6: return p[31:0];
      5'd7: return a << sh;
      5'd8: return a >> sh;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result      = ref_res(alu_ctrl, alu_a, alu_b, alu_shift);
  assign alu_mult_res    = ref_prod(alu_a, alu_b);
  assign alu_is_zero     = (alu_result == 32'd0);
  assign alu_is_negative = alu_result[31];

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [98:0] exp_q[$];
  int          due_q[$];
  logic        m_last = 1'b1;
  logic [63:0] m_hilo = 64'd0;
  bit          m_busy = 1'b0;
  int          m_free_cyc = 32'h7fffffff;
  bit          rm_active = 1'b0;
  logic [98:0] rm_cur;
  int          rr_mode = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor: predicts round-robin winner and pushes expected response.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      logic        p, mult;
      logic [4:0]  c, sh;
      logic [31:0] a, b, r;
      if (m_busy && cyc >= m_free_cyc) m_busy = 1'b0;
      if (m_busy) begin
        check("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
      end else if (req0_valid || req1_valid) begin
        p = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        check("grant", {req1_ready, req0_ready}, p ? 2'b10 : 2'b01);
        c  = p ? req1_ctrl  : req0_ctrl;
        a  = p ? req1_a     : req0_a;
        b  = p ? req1_b     : req0_b;
        sh = p ? req1_shift : req0_shift;
        r  = ref_res(c, a, b, sh);
        mult = (c == 5'd4) || (c == 5'd5) || (c == 5'd6);
        if (c == 5'd4) m_hilo = ref_prod(a, b);
        else if (c == 5'd5 || c == 5'd6) m_hilo = m_hilo + ref_prod(a, b);
        exp_q.push_back({p, r, r == 32'd0, r[31], m_hilo});
        due_q.push_back(cyc + 1 + (mult ? MC : 1));
        m_last     = p;
        m_busy     = 1'b1;
        m_free_cyc = 32'h7fffffff;
      end
    end
  end

  // Response monitor: pops on first sight of each response, checks every held cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      if (!rm_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          rm_cur = exp_q.pop_front();
          check("rsp_latency", cyc, due_q.pop_front());
          rm_active = 1'b1;
        end
      end
      if (rm_active) begin
        check("rsp", {rsp_id, rsp_result, rsp_is_zero, rsp_is_negative, hi_lo}, rm_cur);
        check("mult_in", alu_mult_in, rm_cur[63:0]);
        if (rsp_ready) begin
          rm_active  = 1'b0;
          m_free_cyc = cyc + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    case (rr_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bit p, input logic [4:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh);
    if (p) begin
      req1_ctrl = c; req1_a = a; req1_b = b; req1_shift = sh; req1_valid = 1'b1;
    end else begin
      req0_ctrl = c; req0_a = a; req0_b = b; req0_shift = sh; req0_valid = 1'b1;
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (p ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        @(posedge clk);
        #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout port=%0d never accepted", p);
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && !rm_active && !m_busy) begin
        #1;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    due_q.delete();
    m_last = 1'b1;
    m_hilo = 64'd0;
    m_busy = 1'b0;
    rm_active = 1'b0;
    #1;
    check("reset_outputs",
          {rsp_valid, rsp_id, rsp_result, rsp_is_zero, rsp_is_negative, hi_lo, alu_a,
           alu_b, alu_ctrl, alu_shift, req0_ready, req1_ready, alu_mult_in, dbg_state},
          256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_port(input bit p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(p, 5'($urandom_range(0, 12)), $urandom,
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4)),
           5'($urandom_range(0, 31)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req0_valid = 0; req1_valid = 0;
    req0_ctrl = 0; req0_a = 0; req0_b = 0; req0_shift = 0;
    req1_ctrl = 0; req1_a = 0; req1_b = 0; req1_shift = 0;
    rsp_ready = 1'b1;
    rst = 1'b1;

    do_reset();
    send(0, 5'd0, 32'd5, 32'd7, 5'd0);
    wait_idle();
    check("add_result", {rsp_id, rsp_result, rsp_is_zero}, {1'b0, 32'd12, 1'b0});

    do_reset();
    fork
      begin
        send(0, 5'd1, 32'd3, 32'd3, 5'd0);
        send(0, 5'd1, 32'd3, 32'd3, 5'd0);
      end
      send(1, 5'd3, 32'hF0, 32'h0F, 5'd0);
    join
    wait_idle();

    send(0, 5'd4, 32'h10000, 32'h10000, 5'd0);
    send(0, 5'd5, 32'd2, 32'd3, 5'd0);
    wait_idle();
    check("hilo_madd", hi_lo, 64'h1_0000_0006);

    send(1, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    send(1, 5'd5, 32'd2, 32'hFFFF_FFFF, 5'd0);
    wait_idle();
    check("hilo_ones", hi_lo, 64'hFFFF_FFFF_FFFF_FFFF);
    send(0, 5'd6, 32'd1, 32'd1, 5'd0);
    wait_idle();
    check("hilo_wrap", hi_lo, 64'd0);

    rr_mode = 1;
    fork
      send(0, 5'd2, 32'hDEAD_BEEF, 32'h0FF0_0FF0, 5'd0);
      send(1, 5'd7, 32'h8000_0001, 32'd0, 5'd4);
      begin
        repeat (7) @(posedge clk);
        #1;
        rr_mode = 0;
      end
    join
    wait_idle();

    send(0, 5'd4, 32'd9, 32'd9, 5'd0);
    do_reset();
    send(1, 5'd0, 32'd100, 32'd23, 5'd0);
    wait_idle();
    check("post_reset_rsp", {rsp_id, rsp_result}, {1'b1, 32'd123});

    rr_mode = 2;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    rr_mode = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule
